// File: rtl/bounce_scanner_pkg.sv
// Shared definitions for the bounce scanner: bounce direction codes and
// the scanner state encoding.
package bounce_scanner_pkg;

    // Bounce direction reported with a hit
    typedef enum logic [1:0] {
        B_UP    = 2'd0,
        B_DOWN  = 2'd1,
        B_LEFT  = 2'd2,
        B_RIGHT = 2'd3
    } dir_e;

    // Scanner sequencing states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/bounce_scanner_if.sv
// Bus between the game FSM / brick-state RAM (master) and the scanner (slave).
// SCAN_ALL_EN adds the hit_cnt result.
interface bounce_scanner_if #(
    parameter int IDX_W   = 5,
    parameter int COORD_W = 10,
    parameter int RAD_W   = 6
);
    logic               start;
    logic [COORD_W-1:0] b_x;
    logic [COORD_W-1:0] b_y;
    logic [RAD_W-1:0]   b_radius;
    logic [IDX_W-1:0]   obj_addr;
    logic               obj_rd;
    logic               obj_alive;
    logic [COORD_W-1:0] obj_x;
    logic [COORD_W-1:0] obj_y;
    logic [RAD_W-1:0]   obj_rx;
    logic [RAD_W-1:0]   obj_ry;
    logic               busy;
    logic               done;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic [1:0]         hit_dir;
`ifdef SCAN_ALL_EN
    logic [IDX_W:0]     hit_cnt;

    modport master (
        output start, b_x, b_y, b_radius, obj_alive, obj_x, obj_y, obj_rx, obj_ry,
        input  obj_addr, obj_rd, busy, done, hit, hit_idx, hit_dir, hit_cnt
    );
    modport slave (
        input  start, b_x, b_y, b_radius, obj_alive, obj_x, obj_y, obj_rx, obj_ry,
        output obj_addr, obj_rd, busy, done, hit, hit_idx, hit_dir, hit_cnt
    );
`else
    modport master (
        output start, b_x, b_y, b_radius, obj_alive, obj_x, obj_y, obj_rx, obj_ry,
        input  obj_addr, obj_rd, busy, done, hit, hit_idx, hit_dir
    );
    modport slave (
        input  start, b_x, b_y, b_radius, obj_alive, obj_x, obj_y, obj_rx, obj_ry,
        output obj_addr, obj_rd, busy, done, hit, hit_idx, hit_dir
    );
`endif
endinterface

// File: rtl/bounce_eval.sv
// Combinational overlap and bounce-direction check of the ball against one
// table entry. All sums are two bits wider than a coordinate so that objects
// near the right/bottom edge cannot wrap around and be missed.
module bounce_eval
    import bounce_scanner_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int RAD_W   = 6
) (
    input  logic [COORD_W-1:0] b_x,
    input  logic [COORD_W-1:0] b_y,
    input  logic [RAD_W-1:0]   r,
    input  logic               alive,
    input  logic [COORD_W-1:0] ox,
    input  logic [COORD_W-1:0] oy,
    input  logic [RAD_W-1:0]   rx,
    input  logic [RAD_W-1:0]   ry,
    output logic               hit,
    output logic [1:0]         dir
);
    localparam int W = COORD_W + 2;

    logic [W-1:0] bxw, byw, rw, hw, oxw, oyw, rxw, ryw;
    logic         range_x, range_y;

    assign bxw = W'(b_x);
    assign byw = W'(b_y);
    assign rw  = W'(r);
    assign hw  = W'(r >> 1);
    assign oxw = W'(ox);
    assign oyw = W'(oy);
    assign rxw = W'(rx);
    assign ryw = W'(ry);

    // Overlap on both axes, then pick the face that was crossed
    always_comb begin
        range_x = (bxw < rw + oxw + rxw) && (bxw + rw + rxw >= oxw);
        range_y = (byw < rw + oyw + ryw) && (byw + rw + ryw >= oyw);
        hit     = alive && range_x && range_y;
        dir     = B_DOWN;
        if ((bxw < oxw) && (bxw + hw + rxw < oxw))
            dir = B_LEFT;
        else if ((bxw > oxw) && (bxw > hw + oxw + rxw))
            dir = B_RIGHT;
        else if (byw < oyw)
            dir = B_UP;
    end
endmodule

// File: rtl/bounce_scanner.sv
// Sequential collision scanner: reads one table entry per clock, evaluates
// it the following cycle and reports the lowest-index hit.
// Optional SCAN_ALL_EN: never stop early and count all live hits (hit_cnt).
module bounce_scanner
    import bounce_scanner_pkg::*;
#(
    parameter int NUM_OBJ = 32,
    parameter int IDX_W   = 5,
    parameter int COORD_W = 10,
    parameter int RAD_W   = 6
) (
    input logic             clk,
    input logic             rst_n,
    bounce_scanner_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_OBJ - 1);

    state_e             st;
    logic [COORD_W-1:0] bx, by;
    logic [RAD_W-1:0]   br;
    logic [IDX_W-1:0]   addr, eval_idx, hit_idx_q;
    logic               rd_q, eval_vld, busy_q, done_q, hit_q;
    logic [1:0]         hit_dir_q, e_dir;
    logic               e_hit, eval_hit, stop;

    bounce_eval #(.COORD_W(COORD_W), .RAD_W(RAD_W)) u_eval (
        .b_x  (bx),
        .b_y  (by),
        .r    (br),
        .alive(bus.obj_alive),
        .ox   (bus.obj_x),
        .oy   (bus.obj_y),
        .rx   (bus.obj_rx),
        .ry   (bus.obj_ry),
        .hit  (e_hit),
        .dir  (e_dir)
    );

    // Returned data is only meaningful the cycle after a read was issued
    assign eval_hit = eval_vld && e_hit;

`ifdef SCAN_ALL_EN
    logic [IDX_W:0] cnt_q;
    assign stop        = 1'b0;
    assign bus.hit_cnt = cnt_q;
`else
    assign stop = eval_hit;
`endif

    // A hit squashes the read being issued in the same cycle, so nothing
    // past the hitting entry is fetched beyond the one already in flight.
    assign bus.obj_rd   = rd_q && !stop;
    assign bus.obj_addr = addr;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hit      = hit_q;
    assign bus.hit_idx  = hit_idx_q;
    assign bus.hit_dir  = hit_dir_q;

    // Scan FSM with evaluate stage and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= S_IDLE;
            bx        <= '0;
            by        <= '0;
            br        <= '0;
            addr      <= '0;
            rd_q      <= 1'b0;
            eval_vld  <= 1'b0;
            eval_idx  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
            hit_dir_q <= '0;
`ifdef SCAN_ALL_EN
            cnt_q     <= '0;
`endif
        end else begin
            eval_vld <= bus.obj_rd;
            eval_idx <= addr;
            if (eval_hit) begin
                if (!hit_q) begin
                    hit_q     <= 1'b1;
                    hit_idx_q <= eval_idx;
                    hit_dir_q <= e_dir;
                end
`ifdef SCAN_ALL_EN
                if (cnt_q != (IDX_W+1)'(NUM_OBJ))
                    cnt_q <= cnt_q + 1'b1;
`endif
            end
            case (st)
                S_IDLE: begin
                    if (bus.start) begin
                        bx        <= bus.b_x;
                        by        <= bus.b_y;
                        br        <= bus.b_radius;
                        hit_q     <= 1'b0;
                        hit_idx_q <= '0;
                        hit_dir_q <= '0;
`ifdef SCAN_ALL_EN
                        cnt_q     <= '0;
`endif
                        addr      <= '0;
                        rd_q      <= 1'b1;
                        busy_q    <= 1'b1;
                        st        <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (stop) begin
                        rd_q   <= 1'b0;
                        done_q <= 1'b1;
                        st     <= S_DONE;
                    end else if (addr == LAST) begin
                        rd_q <= 1'b0;
                        st   <= S_DRAIN;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    done_q <= 1'b1;
                    st     <= S_DONE;
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    addr   <= '0;
                    st     <= S_IDLE;
                end
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bounce_scanner.sv
// Directed bench for bounce_scanner with a table RAM model and a queue of
// expected scan results. Honours SCAN_ALL_EN when defined.
module tb_bounce_scanner;
    import bounce_scanner_pkg::*;

    localparam int N = 32;
`ifdef SCAN_ALL_EN
    localparam bit ALL = 1'b1;
`else
    localparam bit ALL = 1'b0;
`endif

    typedef struct {
        int   done_cyc;
        logic hit;
        int   idx;
        int   dir;
        int   cnt;
        int   last_rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    logic       t_alive[N];
    logic [9:0] t_x[N];
    logic [9:0] t_y[N];
    logic [5:0] t_rx[N];
    logic [5:0] t_ry[N];

    always #5 clk = ~clk;

    bounce_scanner_if #(.IDX_W(5), .COORD_W(10), .RAD_W(6)) bif();

    bounce_scanner #(.NUM_OBJ(N), .IDX_W(5), .COORD_W(10), .RAD_W(6)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif)
    );

    // Table RAM: data appears one cycle after the read strobe
    always @(posedge clk) begin
        if (bif.obj_rd) begin
            bif.obj_alive <= t_alive[bif.obj_addr];
            bif.obj_x     <= t_x[bif.obj_addr];
            bif.obj_y     <= t_y[bif.obj_addr];
            bif.obj_rx    <= t_rx[bif.obj_addr];
            bif.obj_ry    <= t_ry[bif.obj_addr];
        end else begin
            bif.obj_alive <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic clear_table();
        for (int i = 0; i < N; i++) begin
            t_alive[i] = 1'b0;
            t_x[i] = 10'd600;
            t_y[i] = 10'd600;
            t_rx[i] = 6'd4;
            t_ry[i] = 6'd4;
        end
    endtask

    task automatic set_obj(input int i, input logic a, input logic [9:0] x, input logic [9:0] y,
                           input logic [5:0] rx, input logic [5:0] ry);
        t_alive[i] = a;
        t_x[i] = x;
        t_y[i] = y;
        t_rx[i] = rx;
        t_ry[i] = ry;
    endtask

    // Push expectation for a scan whose first hit is entry k (k<0: none)
    task automatic push_exp(input int k, input int dir, input int cnt);
        exp_t e;
        e.hit      = (k >= 0);
        e.idx      = (k >= 0) ? k : 0;
        e.dir      = dir;
        e.cnt      = cnt;
        e.done_cyc = (ALL || k < 0) ? N + 2 : k + 3;
        e.last_rd  = (ALL || k < 0) ? N : k + 1;
        sb.push_back(e);
    endtask

    task automatic run_scan(input string tag, input logic [9:0] x, input logic [9:0] y,
                            input logic [5:0] r, input bit poke);
        exp_t e;
        int cyc, last_rd, busy_bad;
        bit seen;
        @(posedge clk); #1;
        bif.b_x = x;
        bif.b_y = y;
        bif.b_radius = r;
        bif.start = 1'b1;
        cyc = 0; last_rd = -1; busy_bad = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            bif.start = poke && (cyc == 10 || cyc == 20);
            if (bif.obj_rd === 1'b1) last_rd = cyc;
            if (bif.busy !== 1'b1) busy_bad++;
            seen = (bif.done === 1'b1);
        end
        bif.start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            if (bif.obj_rd === 1'b1) last_rd = cyc + i;
            if (i == 1) begin
                chk({tag, ".busy_after"}, 32'(bif.busy), 0);
                chk({tag, ".done_len"}, 32'(bif.done), 0);
            end
        end
        e = sb.pop_front();
        chk({tag, ".done_cyc"}, seen ? cyc : -1, e.done_cyc);
        chk({tag, ".busy"}, busy_bad, 0);
        chk({tag, ".hit"}, 32'(bif.hit), 32'(e.hit));
        if (e.hit) begin
            chk({tag, ".idx"}, 32'(bif.hit_idx), e.idx);
            chk({tag, ".dir"}, 32'(bif.hit_dir), e.dir);
        end
        chk({tag, ".last_rd"}, last_rd, e.last_rd);
`ifdef SCAN_ALL_EN
        chk({tag, ".cnt"}, 32'(bif.hit_cnt), e.cnt);
`endif
    endtask

    initial begin
        int dn;
        bif.start = 1'b0;
        bif.b_x = '0;
        bif.b_y = '0;
        bif.b_radius = '0;
        clear_table();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 32'(bif.busy), 0);
        chk("rst.done", 32'(bif.done), 0);
        chk("rst.hit", 32'(bif.hit), 0);
        chk("rst.obj_rd", 32'(bif.obj_rd), 0);
        chk("rst.obj_addr", 32'(bif.obj_addr), 0);
        chk("rst.hit_idx", 32'(bif.hit_idx), 0);
        chk("rst.hit_dir", 32'(bif.hit_dir), 0);
        rst_n = 1'b1;

        clear_table();
        set_obj(5, 1'b1, 10'd100, 10'd210, 6'd16, 6'd8);
        push_exp(5, B_UP, 1);
        run_scan("single", 10'd100, 10'd200, 6'd4, 1'b0);

        clear_table();
        set_obj(0, 1'b1, 10'd100, 10'd210, 6'd16, 6'd8);
        push_exp(0, B_LEFT, 1);
        run_scan("left", 10'd80, 10'd210, 6'd4, 1'b0);

        clear_table();
        set_obj(9, 1'b1, 10'd100, 10'd210, 6'd16, 6'd8);
        push_exp(9, B_RIGHT, 1);
        run_scan("right", 10'd119, 10'd210, 6'd4, 1'b0);

        clear_table();
        set_obj(2, 1'b1, 10'd1000, 10'd100, 6'd40, 6'd8);
        push_exp(2, B_DOWN, 1);
        run_scan("ovf", 10'd1000, 10'd100, 6'd40, 1'b0);

        clear_table();
        set_obj(3, 1'b0, 10'd100, 10'd210, 6'd16, 6'd8);
        set_obj(10, 1'b1, 10'd600, 10'd600, 6'd8, 6'd8);
        push_exp(-1, 0, 0);
        run_scan("nohit", 10'd100, 10'd200, 6'd4, 1'b1);

        clear_table();
        set_obj(7, 1'b1, 10'd100, 10'd210, 6'd16, 6'd8);
        set_obj(4, 1'b1, 10'd100, 10'd210, 6'd16, 6'd8);
        push_exp(4, B_UP, 2);
        run_scan("prio", 10'd100, 10'd200, 6'd4, 1'b0);

        // Reset in the middle of a scan
        clear_table();
        @(posedge clk); #1;
        bif.b_x = 10'd100;
        bif.b_y = 10'd200;
        bif.b_radius = 6'd4;
        bif.start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            bif.start = 1'b0;
        end
        chk("mid.busy_pre", 32'(bif.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid.busy", 32'(bif.busy), 0);
        chk("mid.done", 32'(bif.done), 0);
        chk("mid.hit", 32'(bif.hit), 0);
        chk("mid.obj_rd", 32'(bif.obj_rd), 0);
        chk("mid.obj_addr", 32'(bif.obj_addr), 0);
        chk("mid.hit_idx", 32'(bif.hit_idx), 0);
        chk("mid.hit_dir", 32'(bif.hit_dir), 0);
        dn = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (bif.done === 1'b1) dn++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (bif.done === 1'b1 || bif.busy === 1'b1) dn++;
        end
        chk("mid.no_done", dn, 0);

        set_obj(5, 1'b1, 10'd100, 10'd210, 6'd16, 6'd8);
        push_exp(5, B_UP, 1);
        run_scan("after_rst", 10'd100, 10'd200, 6'd4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bounce_scanner.md
Name: bounce_scanner

Overview:
- Sequential successor to the single-object overlap check.
- Walks a table of up to NUM_OBJ wall/brick objects, one per clock, against one ball position.
- Reports the first colliding object's index and bounce direction.
- Sits between the frame-tick ball-update logic and the brick-state RAM. The game FSM pulses start once per frame and waits for done.

Parameters:
- NUM_OBJ, 32, number of table entries scanned (2..256).
- IDX_W, 5, index width; must satisfy 2**IDX_W >= NUM_OBJ.
- COORD_W, 10, coordinate width (x, y).
- RAD_W, 6, radius width (ball radius, object half-extents).

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle scan request; sampled only in IDLE.
- b_x, in, COORD_W, ball x; latched on accepted start.
- b_y, in, COORD_W, ball y; latched on accepted start.
- b_radius, in, RAD_W, ball radius; latched on accepted start.
- obj_addr, out, IDX_W, table read address.
- obj_rd, out, 1, table read strobe; data is returned exactly one cycle later.
- obj_alive, in, 1, entry valid/unbroken.
- obj_x, obj_y, in, COORD_W each, object centre.
- obj_rx, obj_ry, in, RAD_W each, object half-extents.
- busy, out, 1, scan in progress.
- done, out, 1, one-cycle pulse when the result is valid.
- hit, out, 1, a collision was found.
- hit_idx, out, IDX_W, index of the first colliding object.
- hit_dir, out, 2, B_UP/B_DOWN/B_LEFT/B_RIGHT code.

Behaviour:
- Reset: state IDLE; busy, done, hit, obj_rd = 0; obj_addr, hit_idx, hit_dir = 0.
- Reset asserted mid-scan aborts immediately. No done pulse is issued.
- States:
  - IDLE: start=1 latches the ball inputs, clears hit, and goes to SCAN.
  - SCAN: issues obj_rd with obj_addr = 0..NUM_OBJ-1, one per cycle.
  - DRAIN: one cycle to evaluate the last returned entry.
  - DONE: pulses done for one cycle, then returns to IDLE.
- Timing: with start accepted at cycle 0, address k is issued at cycle k+1 and evaluated at cycle k+2.
  - No hit: done at cycle NUM_OBJ+2.
  - First hit at entry k: the scan stops, no further reads are issued, and done is at cycle k+3. Any read already in flight is discarded.
- busy is high from cycle 1 through the done cycle inclusive.
- start is ignored while busy.
- hit, hit_idx and hit_dir hold their values until the next accepted start.
- An entry is evaluated only if obj_alive=1. Dead entries never hit.
- Overlap test, with all sums computed at COORD_W+2 bits (no wrap):
  - range_x = b_x < r+ox+rx AND b_x+r+rx >= ox.
  - range_y is the same form using y and ry.
- Direction, first match wins (r/2 = floor):
  - b_x<ox AND b_x+r/2+rx<ox gives B_LEFT.
  - b_x>ox AND b_x>r/2+ox+rx gives B_RIGHT.
  - b_y<oy gives B_UP.
  - otherwise B_DOWN.
- Priority: the lowest index wins.

Optional Feature:
- SCAN_ALL_EN.
- Defined:
  - The scan never stops early. done is always at cycle NUM_OBJ+2.
  - hit, hit_idx and hit_dir still report the lowest-index hit.
  - Extra output hit_cnt (IDX_W+1 bits) holds the number of colliding live entries, saturating at NUM_OBJ.
  - Lets the game FSM break several bricks per frame.
- Undefined: early exit as above, and no hit_cnt port.

Decomposition:
- B_UP/B_DOWN/B_LEFT/B_RIGHT direction codes stay in the shared def.v definitions. The scanner state encoding is added there too.
- Natural sub-module: bounce_eval. It is a combinational overlap plus direction check on one entry, with COORD_W+2 internal arithmetic. It is instantiated once in the evaluate stage.

Test Plan:
- Single hit:
  - Stimulus: ball (100,200) r=4; entry 5 alive at (100,210) rx=16 ry=8; all other entries dead; start at cycle 0.
  - Required: done at cycle 8; hit=1, hit_idx=5, hit_dir=B_UP; no obj_rd after cycle 6.
- Left side:
  - Stimulus: ball (80,210) r=4 against entry 0 at (100,210) rx=16 ry=8.
  - Required: done at cycle 3, hit_dir=B_LEFT.
- Overflow:
  - Stimulus: ball (1000,100) r=40; entry 2 at (1000,100) rx=40 ry=8.
  - Required: hit, hit_idx=2, hit_dir=B_DOWN. This must not be missed through 10-bit wrap.
- No hit and dead skip:
  - Stimulus: entry 3 overlapping but obj_alive=0; no other overlaps.
  - Required: done at cycle 34 (NUM_OBJ=32), hit=0. start pulses at cycles 10 and 20 are ignored.
- Priority:
  - Stimulus: entries 7 and 4 both overlapping.
  - Required: hit_idx=4. With SCAN_ALL_EN: done at cycle 34, hit_cnt=2.
- Reset mid-scan:
  - Stimulus: rst_n low at cycle 12, release, then a new start.
  - Required: all outputs 0 immediately; no done for the aborted scan; the new scan completes normally.
